// File: rtl/up_down_counter_pkg.sv
// Shared definitions for the modulo up/down counter: boundary modes and the
// per-edge action encoding used by the RTL and its bench.
package up_down_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        ACT_CLEAR = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_COUNT = 2'd2,
        ACT_HOLD  = 2'd3
    } action_e;

    // Resolve the per-edge controls into the single action that wins: clear > load > count > hold.
    function automatic action_e decode_action(input logic clear,
                                              input logic load,
                                              input logic enable);
        if (clear)       return ACT_CLEAR;
        else if (load)   return ACT_LOAD;
        else if (enable) return ACT_COUNT;
        else             return ACT_HOLD;
    endfunction

endpackage

// File: rtl/up_down_counter_mod_next.sv
// Next-count arithmetic for the modulo up/down counter: computes the value one
// enabled step would produce and whether that step hits a boundary.
module up_down_next
    import up_down_counter_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [BITS-1:0] q,
    input  logic            up,
    input  logic [BITS-1:0] limit,
    output logic [BITS-1:0] q_next,
    output logic            boundary
);

    localparam logic IS_SAT = (SATURATE == MODE_SAT);

    always_comb begin
        // NOTE: every output gets a default before the branches so no path leaves it unassigned and infers a latch.
        q_next   = q;
        boundary = 1'b0;
        if (up) begin
            if (q >= limit) begin
                boundary = 1'b1;
                q_next   = IS_SAT ? limit : '0;
            end else begin
                q_next = q + 1'b1;
            end
        end else begin
            // A limit lowered under the count pulls Q back into range without counting as a boundary.
            if (q > limit) begin
                q_next = limit;
            end else if (q == '0) begin
                boundary = 1'b1;
                q_next   = IS_SAT ? '0 : limit;
            end else begin
                q_next = q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Modulo-N up/down counter with synchronous clear/load, wrap or saturate at
// the boundaries, a one-cycle terminal-count pulse and a sticky overflow flag.
module up_down_counter_mod
    import up_down_counter_pkg::*;
#(
    parameter int          BITS      = 8,
    parameter int          SATURATE  = MODE_WRAP,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic [BITS-1:0] limit,
    output logic [BITS-1:0] Q,
    output logic            at_max,
    output logic            at_min,
    output logic            tc,
    output logic            ovf
);

    localparam logic [BITS-1:0] RST_Q = BITS'(RESET_VAL);

    logic [BITS-1:0] q_next;
    logic            boundary;
    logic [BITS-1:0] load_clamped;
    action_e         action;

    up_down_next #(
        .BITS     (BITS),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (Q),
        .up       (up),
        .limit    (limit),
        .q_next   (q_next),
        .boundary (boundary)
    );

    assign action       = decode_action(clear, load, enable);
    assign load_clamped = (load_val > limit) ? limit : load_val;
    assign at_max       = (Q >= limit);
    assign at_min       = (Q == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q   <= RST_Q;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            unique case (action)
                ACT_CLEAR: begin
                    Q   <= RST_Q;
                    tc  <= 1'b0;
                    ovf <= 1'b0;
                end
                ACT_LOAD: begin
                    Q  <= load_clamped;
                    tc <= 1'b0;
                end
                ACT_COUNT: begin
                    Q   <= q_next;
                    tc  <= boundary;
                    ovf <= ovf | boundary;
                end
                ACT_HOLD: begin
                    tc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod: a wrap instance (RESET_VAL 0) and a
// saturate instance (RESET_VAL 2) share stimulus; each section checks one of them.
module tb_up_down_counter_mod;
    import up_down_counter_pkg::*;

    localparam int BITS = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable, up, clear, load;
    logic [BITS-1:0] load_val, limit;

    logic [BITS-1:0] w_q, s_q;
    logic            w_at_max, w_at_min, w_tc, w_ovf;
    logic            s_at_max, s_at_min, s_tc, s_ovf;

    int n_vec  = 0;
    int n_miss = 0;

    up_down_counter_mod #(.BITS(BITS), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .limit(limit),
        .Q(w_q), .at_max(w_at_max), .at_min(w_at_min), .tc(w_tc), .ovf(w_ovf)
    );

    up_down_counter_mod #(.BITS(BITS), .SATURATE(MODE_SAT), .RESET_VAL(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .limit(limit),
        .Q(s_q), .at_max(s_at_max), .at_min(s_at_min), .tc(s_tc), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_act(input action_e a);
        clear  = (a == ACT_CLEAR);
        load   = (a == ACT_LOAD);
        enable = (a == ACT_COUNT);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_q1[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_q3u[8]  = '{1, 2, 3, 4, 5, 5, 5, 5};
    int exp_tc3u[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    int exp_q3d[7]  = '{4, 3, 2, 1, 0, 0, 0};
    int exp_tc3d[7] = '{0, 0, 0, 0, 0, 1, 1};

    initial begin
        reset_n  = 1'b0;
        set_act(ACT_HOLD);
        up       = 1'b1;
        load_val = '0;
        limit    = 4'd9;
        #12;
        check("rst_w_q",   w_q, 0);
        check("rst_w_tc",  w_tc, 0);
        check("rst_w_ovf", w_ovf, 0);
        check("rst_w_min", w_at_min, 1);
        check("rst_w_max", w_at_max, 0);
        check("rst_s_q",   s_q, 2);
        @(negedge clk);
        reset_n = 1'b1;

        // Wrap, limit 9, count up 12.
        set_act(ACT_COUNT);
        up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("up_q[%0d]", i),   w_q, exp_q1[i]);
            check($sformatf("up_tc[%0d]", i),  w_tc, (i == 9));
            check($sformatf("up_ovf[%0d]", i), w_ovf, (i >= 9));
            if (i == 8) check("up_at_max9", w_at_max, 1);
        end

        // Clear, then count down from 0.
        set_act(ACT_CLEAR);
        tick();
        check("clr_q",   w_q, 0);
        check("clr_ovf", w_ovf, 0);
        set_act(ACT_COUNT);
        up = 1'b0;
        tick(); check("dn_q0", w_q, 9); check("dn_tc0", w_tc, 1); check("dn_ovf0", w_ovf, 1);
        tick(); check("dn_q1", w_q, 8); check("dn_tc1", w_tc, 0);
        tick(); check("dn_q2", w_q, 7); check("dn_tc2", w_tc, 0);

        // Saturate instance, limit 5.
        limit    = 4'd5;
        load_val = 4'd0;
        set_act(ACT_LOAD);
        tick();
        check("sat_load0", s_q, 0);
        set_act(ACT_COUNT);
        up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("sat_up_q[%0d]", i),  s_q, exp_q3u[i]);
            check($sformatf("sat_up_tc[%0d]", i), s_tc, exp_tc3u[i]);
        end
        check("sat_ovf", s_ovf, 1);
        up = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("sat_dn_q[%0d]", i),  s_q, exp_q3d[i]);
            check($sformatf("sat_dn_tc[%0d]", i), s_tc, exp_tc3d[i]);
        end
        check("sat_at_min", s_at_min, 1);

        // Load priority and clamping on the wrap instance (ovf is 1 here).
        limit    = 4'd9;
        load_val = 4'd3;
        set_act(ACT_LOAD);
        tick();
        check("ld_q3", w_q, 3);
        load_val = 4'd12;
        clear    = 1'b0; load = 1'b1; enable = 1'b1;
        tick();
        check("ld_clamp_q",  w_q, 9);
        check("ld_clamp_tc", w_tc, 0);
        check("ld_keep_ovf", w_ovf, 1);
        clear = 1'b1; load = 1'b1; enable = 1'b1;
        tick();
        check("clr_ld_w_q",   w_q, 0);
        check("clr_ld_w_ovf", w_ovf, 0);
        check("clr_ld_s_q",   s_q, 2);
        check("clr_ld_s_ovf", s_ovf, 0);

        // Limit lowered below Q.
        load_val = 4'd8;
        set_act(ACT_LOAD);
        tick();
        limit = 4'd4;
        #1;
        check("low_at_max", w_at_max, 1);
        set_act(ACT_COUNT);
        up = 1'b0;
        tick();
        check("low_dn_q",  w_q, 4);
        check("low_dn_tc", w_tc, 0);
        limit = 4'd9;
        set_act(ACT_LOAD);
        tick();
        limit = 4'd4;
        set_act(ACT_COUNT);
        up = 1'b1;
        tick();
        check("low_up_q",   w_q, 0);
        check("low_up_tc",  w_tc, 1);
        check("low_up_ovf", w_ovf, 1);

        // limit 0: every enabled edge wraps, tc stays high.
        limit = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lim0_q[%0d]", i),  w_q, 0);
            check($sformatf("lim0_tc[%0d]", i), w_tc, 1);
        end

        // Full range: 15 -> 0 is natural overflow.
        limit    = 4'd15;
        load_val = 4'd15;
        set_act(ACT_LOAD);
        tick();
        check("full_at_max", w_at_max, 1);
        set_act(ACT_COUNT);
        tick();
        check("full_q",  w_q, 0);
        check("full_tc", w_tc, 1);

        // Hold with up toggling.
        set_act(ACT_HOLD);
        for (int i = 0; i < 2; i++) begin
            up = ~up;
            tick();
            check($sformatf("hold_q[%0d]", i),  w_q, 0);
            check($sformatf("hold_tc[%0d]", i), w_tc, 0);
        end

        // Async reset mid-cycle with Q=6, ovf=1.
        limit    = 4'd9;
        load_val = 4'd6;
        set_act(ACT_LOAD);
        tick();
        check("pre_rst_q",   w_q, 6);
        check("pre_rst_ovf", w_ovf, 1);
        set_act(ACT_COUNT);
        up = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_q",   w_q, 0);
        check("arst_ovf", w_ovf, 0);
        check("arst_s_q", s_q, 2);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("resume_w_q", w_q, 1);
        check("resume_s_q", s_q, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
Parametrised synchronous up/down counter with a run-time programmable modulus, synchronous load and clear, and a build-time choice of wrap or saturate at the boundaries. It reports boundary events as a one-cycle pulse and as a sticky flag. It replaces the plain up/down counter wherever a decade/modulo-N count, a preset, or a bounded (non-wrapping) count is needed: timers, divide-by-N, position/credit trackers.

Parameters:
BITS, 8, counter width; legal range 2..32.
SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries.
RESET_VAL, 0, value Q takes on reset and on clear; must be <= 2**BITS-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  count enable; when low, Q holds (load and clear still act).
up  input  1  1 = count up, 0 = count down.
clear  input  1  synchronous clear to RESET_VAL; also clears ovf.
load  input  1  synchronous load of load_val.
load_val  input  BITS  preset value.
limit  input  BITS  top of count range; the counter spans 0..limit inclusive.
Q  output  BITS  registered count.
at_max  output  1  combinational: Q >= limit.
at_min  output  1  combinational: Q == 0.
tc  output  1  registered one-cycle pulse: a boundary step occurred on the last edge.
ovf  output  1  registered sticky flag: at least one boundary step since reset or clear.

Behaviour:
- Reset (reset_n low, asynchronous): Q=RESET_VAL, tc=0, ovf=0. Release is synchronous to clk.
- Per-edge priority is clear > load > enable-count > hold. Exactly one action per cycle.
- clear: Q<=RESET_VAL, tc<=0, ovf<=0. It ignores enable, load and limit.
- load: Q<=min(load_val, limit), tc<=0, ovf unchanged. It ignores enable.
- Count, with enable=1 and no clear/load:
  - up, Q<limit: Q<=Q+1.
  - up, Q>=limit (boundary): wrap mode Q<=0; saturate mode Q<=limit.
  - down, Q>limit (limit lowered below Q): Q<=limit. This is not a boundary step.
  - down, 0<Q<=limit: Q<=Q-1.
  - down, Q==0 (boundary): wrap mode Q<=limit; saturate mode Q<=0.
- Boundary step: tc<=1 for exactly one cycle and ovf<=1. This applies in both modes; in saturate mode, every enabled cycle spent pinned at the boundary re-pulses tc.
- Any edge that is not a boundary step drives tc<=0.
- Latency: Q, tc and ovf change one edge after the controlling inputs are sampled. at_max and at_min follow Q combinationally, and also follow limit.
- limit==0: Q stays 0. In wrap mode, every enabled edge is a boundary step, so tc is held high continuously.
- Arithmetic: unsigned, BITS wide, no carry out. limit=2**BITS-1 gives a full-range binary counter; the wrap result equals natural overflow.
- enable=0 with up toggling: no state change.

Decomposition:
- Shared package up_down_counter_pkg holds:
  - mode constants MODE_WRAP=0 and MODE_SAT=1;
  - the action encoding (ACT_CLEAR, ACT_LOAD, ACT_COUNT, ACT_HOLD) used by RTL and bench.
- One combinational sub-module, up_down_next:
  - inputs: Q, up, limit, SATURATE;
  - outputs: next value and the boundary flag.
- The top module holds the priority mux and the Q/tc/ovf registers.

Test Plan:
1. BITS=4, wrap, limit=9, count up 12 cycles from reset. Required: Q=0..9,0,1,2; tc high only in the cycle after 9→0; ovf=1 from then on.
2. Same configuration, count down from 0 for 3 cycles. Required: Q=9,8,7; tc pulses once after 0→9.
3. SATURATE=1, limit=5, count up 8 cycles. Required: Q=1..5,5,5,5; tc high on each of the 3 pinned cycles. Then count down 7 cycles: Q=4..0,0,0; tc pulses twice.
4. Load priority. With Q=3 and limit=9, assert load with load_val=12 and enable=1. Required: Q=9, tc=0. Then assert load and clear together: Q=RESET_VAL and ovf=0.
5. Limit lowered. With Q=8, set limit=4 and count down. Required: Q=4, no tc. Separately with Q=8, limit=4, count up: Q=0, tc=1.
6. Asynchronous reset mid-count. Assert reset_n low between edges while Q=6 and ovf=1. Required: Q=RESET_VAL and ovf=0 immediately, without waiting for a clk edge. Counting resumes from RESET_VAL on the first edge after release with enable=1.
